// File: rtl/debug_sequencer.sv
// Debug command engine: burst memory access, register reads and a breakpoint
// table, with read data returned over a valid/ready response channel.
module debug_sequencer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_BKP = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [2:0]        CMD_OP,
  input  logic [2:0]        CMD_ARG,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [CNT_W-1:0]  CMD_COUNT,
  input  logic              CMD_INC,
  output logic              BUS_REQ,
  output logic              BUS_WR,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [DATA_W-1:0] BUS_WDATA,
  input  logic              BUS_ACK,
  input  logic [DATA_W-1:0] BUS_RDATA,
  output logic [2:0]        REG_SEL,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  input  logic              RSP_READY,
  input  logic [ADDR_W-1:0] PC_I,
  output logic              BKP_HIT
);

  localparam logic [2:0] OP_WR_BKP  = 3'd1;
  localparam logic [2:0] OP_RD_REG  = 3'd2;
  localparam logic [2:0] OP_RD_MEM  = 3'd3;
  localparam logic [2:0] OP_WR_MEM  = 3'd4;
  localparam logic [2:0] OP_CLR_BKP = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    REG_WAIT,
    REG_RSP,
    BUS_BEAT,
    BUS_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              inc_q, inc_d;
  logic [2:0]        reg_sel_q, reg_sel_d;
  logic              bus_req_q, bus_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              bkp_wr, bkp_clr;

  logic [ADDR_W-1:0] bkp_addr_q [NUM_BKP];
  logic [NUM_BKP-1:0] bkp_en_q;
  logic              bkp_hit_q, bkp_hit_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    inc_d       = inc_q;
    reg_sel_d   = reg_sel_q;
    bus_req_d   = bus_req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    bkp_wr      = 1'b0;
    bkp_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          case (CMD_OP)
            OP_WR_BKP:  bkp_wr  = 1'b1;
            OP_CLR_BKP: bkp_clr = 1'b1;
            OP_RD_REG: begin
              reg_sel_d = CMD_ARG;
              state_d   = REG_WAIT;
            end
            OP_RD_MEM, OP_WR_MEM: begin
              addr_d    = CMD_ADDR;
              wdata_d   = CMD_DATA;
              cnt_d     = CMD_COUNT;
              inc_d     = CMD_INC;
              wr_d      = (CMD_OP == OP_WR_MEM);
              bus_req_d = 1'b1;
              state_d   = BUS_BEAT;
            end
            default: ;
          endcase
        end
      end
      REG_WAIT: begin
        rsp_data_d  = REG_RDATA;
        rsp_valid_d = 1'b1;
        state_d     = REG_RSP;
      end
      REG_RSP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      BUS_BEAT: begin
        // Write bursts stay here between beats; the idle cycle after an ack
        // re-raises the request so BUS_REQ always drops for one cycle.
        if (!bus_req_q) begin
          bus_req_d = 1'b1;
        end else if (BUS_ACK) begin
          bus_req_d = 1'b0;
          if (inc_q) addr_d = addr_q + ADDR_W'(1);
          if (!wr_q) begin
            rsp_data_d  = BUS_RDATA;
            rsp_valid_d = 1'b1;
            state_d     = BUS_RSP;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      BUS_RSP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d     = cnt_q - CNT_W'(1);
            bus_req_d = 1'b1;
            state_d   = BUS_BEAT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      inc_q       <= 1'b0;
      reg_sel_q   <= '0;
      bus_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      inc_q       <= inc_d;
      reg_sel_q   <= reg_sel_d;
      bus_req_q   <= bus_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Out-of-range indices match no entry, so those writes fall away.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bkp_en_q <= '0;
      for (int unsigned i = 0; i < NUM_BKP; i++) bkp_addr_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BKP; i++) begin
        if (bkp_wr && CMD_ARG == 3'(i)) begin
          bkp_en_q[i]   <= 1'b1;
          bkp_addr_q[i] <= CMD_ADDR;
        end else if (bkp_clr && CMD_ARG == 3'(i)) begin
          bkp_en_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bkp_hit_d = 1'b0;
    for (int unsigned i = 0; i < NUM_BKP; i++) begin
      if (bkp_en_q[i] && bkp_addr_q[i] == PC_I) bkp_hit_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) bkp_hit_q <= 1'b0;
    else       bkp_hit_q <= bkp_hit_d;
  end

  assign CMD_READY = (state_q == IDLE);
  assign BUS_REQ   = bus_req_q;
  assign BUS_WR    = wr_q;
  assign BUS_ADDR  = addr_q;
  assign BUS_WDATA = wdata_q;
  assign REG_SEL   = reg_sel_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign BKP_HIT   = bkp_hit_q;

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Multi-cycle debug command engine between the debug port front end and the CPU bus/register file. It replaces single-cycle debug op decoding.
- Accepts one command per valid/ready handshake and sequences burst memory reads and writes, with optional address auto-increment.
- Performs register reads and maintains a parametrised breakpoint table.
- Returns read data through a valid/ready response channel with backpressure.

Parameters:
- ADDR_W, 16, bus address and breakpoint address width.
- DATA_W, 16, bus/register data width.
- NUM_BKP, 4, breakpoint table entries (1..8). Entry index is taken from CMD_ARG.
- CNT_W, 8, burst count width. The beat count is CMD_COUNT+1.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous active-high reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  engine idle and able to accept a command.
- CMD_OP  in  3  0 NOP, 1 WR_BKP, 2 RD_REG, 3 RD_MEM, 4 WR_MEM, 5 CLR_BKP; 6/7 are treated as NOP.
- CMD_ARG  in  3  register index (RD_REG) or breakpoint index (WR_BKP/CLR_BKP).
- CMD_ADDR  in  ADDR_W  start address (RD_MEM/WR_MEM) or breakpoint address (WR_BKP).
- CMD_DATA  in  DATA_W  write data for WR_MEM; the same value is written on every beat (fill).
- CMD_COUNT  in  CNT_W  beats minus one for RD_MEM/WR_MEM.
- CMD_INC  in  1  increment the address after each beat.
- BUS_REQ  out  1  bus request, held until BUS_ACK.
- BUS_WR  out  1  1 = write, 0 = read.
- BUS_ADDR  out  ADDR_W  bus address.
- BUS_WDATA  out  DATA_W  bus write data.
- BUS_ACK  in  1  bus beat complete; BUS_RDATA is valid in the same cycle.
- BUS_RDATA  in  DATA_W  bus read data.
- REG_SEL  out  3  register index to the register file.
- REG_RDATA  in  DATA_W  register data, valid 1 cycle after REG_SEL is set.
- RSP_VALID  out  1  response valid.
- RSP_DATA  out  DATA_W  response data.
- RSP_READY  in  1  response accepted.
- PC_I  in  ADDR_W  current PC.
- BKP_HIT  out  1  registered flag: PC_I matches any enabled breakpoint entry.

Behaviour:
- Reset (async, immediate): state = IDLE; every breakpoint entry disabled and its address zeroed; all outputs 0 except CMD_READY = 1. A reset mid-burst aborts the burst with no further bus activity.
- CMD_READY is 1 only in IDLE. A command is accepted on a cycle where CMD_VALID && CMD_READY. All command fields are latched on acceptance, so later changes to the inputs have no effect.
- States: IDLE, REG_WAIT, REG_RSP, BUS_BEAT, BUS_RSP.
- NOP, or an invalid op:
  - Completes in the acceptance cycle.
  - The engine stays in IDLE.
  - No response is generated.
- WR_BKP:
  - Writes entry[CMD_ARG] = {enable=1, addr=CMD_ADDR} in the acceptance cycle.
  - The engine stays in IDLE; no response.
  - If CMD_ARG >= NUM_BKP the write is ignored.
- CLR_BKP: same rules as WR_BKP, but clears the enable bit of the entry.
- RD_REG:
  - IDLE → REG_WAIT, with REG_SEL driven from CMD_ARG.
  - REG_WAIT → REG_RSP, capturing REG_RDATA into RSP_DATA and setting RSP_VALID = 1.
  - REG_RSP holds until RSP_READY, then returns to IDLE.
  - Minimum command-to-response latency is 2 cycles.
- RD_MEM / WR_MEM burst:
  - IDLE → BUS_BEAT with BUS_REQ = 1, BUS_WR = (op == WR_MEM), BUS_ADDR = latched address.
  - BUS_REQ, BUS_WR, BUS_ADDR and BUS_WDATA are held stable until BUS_ACK.
  - On BUS_ACK, BUS_REQ drops for at least 1 cycle.
- RD_MEM beat handling:
  - On BUS_ACK, BUS_RDATA is captured → BUS_RSP, RSP_VALID = 1.
  - When RSP_READY is seen, continue to the next beat in BUS_BEAT, or go to IDLE after the last beat.
  - Exactly one response is produced per beat.
- WR_MEM beat handling: no responses. After the last BUS_ACK the engine returns to IDLE.
- Address update: after each acked beat, if the latched INC is set, address = address + 1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
- Remaining-beat counter: loaded with CMD_COUNT and decremented per beat. The last beat is the one where the counter is 0. CMD_COUNT = 2^CNT_W−1 gives 2^CNT_W beats.
- Response channel:
  - RSP_VALID and RSP_DATA are stable while RSP_READY = 0.
  - RSP_VALID clears the cycle after acceptance.
  - No bus request is issued while a response is pending.
- Breakpoint matching:
  - BKP_HIT is registered: 1 the cycle after PC_I equals any enabled entry address.
  - Matching is evaluated every cycle, independent of engine state.
  - A WR_BKP that writes an entry matching the current PC_I asserts BKP_HIT on the following cycle plus one, because the table write and the compare register each add one cycle.

Test Plan:
- Reset, then RD_REG ARG=5 with REG_RDATA=0xBEEF and RSP_READY=1 → REG_SEL=5; RSP_VALID with RSP_DATA=0xBEEF exactly 2 cycles after acceptance; CMD_READY returns to 1.
- RD_MEM ADDR=0xFFFE, COUNT=2, INC=1, BUS_ACK after 1–3 cycles of random wait → bus addresses 0xFFFE, 0xFFFF, 0x0000; 3 responses in order; BUS_REQ low for ≥1 cycle between beats.
- WR_MEM ADDR=0x0100, DATA=0x1234, COUNT=3, INC=0 → 4 write beats, all to 0x0100 with data 0x1234; no RSP_VALID; return to IDLE after the 4th ack.
- RD_MEM COUNT=1 with RSP_READY held 0 for 5 cycles → RSP_VALID/RSP_DATA stable throughout; no second BUS_REQ until the response is accepted.
- WR_BKP ARG=2 ADDR=0x0040, then PC_I=0x0040 → BKP_HIT=1 next cycle. Then CLR_BKP ARG=2 → BKP_HIT=0. WR_BKP with ARG=7 (NUM_BKP=4) → no entry changes.
- Assert RESET mid-burst (after beat 1 of 4) → BUS_REQ=0 immediately, CMD_READY=1, breakpoints cleared, no further responses.
